// File: rtl/ether_pkg.sv
// Shared definitions for the Ethernet packetizer.
// FSM encoding, field widths and the default header marker.
package ether_pkg;

    localparam int DATA_W   = 16;
    localparam int SEQ_W    = 8;
    localparam int MARKER_W = 8;

    localparam logic [MARKER_W-1:0] MARKER_DEF = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_PAY,
        S_TRL
    } state_t;

endpackage

// File: rtl/ether_fifo.sv
// Synchronous first-word-fall-through FIFO, 16-bit data.
// Head word is visible combinationally so PAY can pop every cycle.
module ether_fifo
    import ether_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_count
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [2**AW];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_wr;
    logic              w_rd;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_count == DEPTH);
    assign o_empty = (o_count == '0);
    assign w_wr    = i_wr && !o_full;
    assign w_rd    = i_rd && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array; contents need no reset, pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Read/write pointers; reset empties the FIFO.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + ONE;
            end
        end
    end

endmodule

// File: rtl/ether_packetizer.sv
// Frames the repacker word stream into header/length/payload/XOR packets.
// Flushes a short packet at end of run and pulses RunDone when drained.
module ether_packetizer
    import ether_pkg::*;
#(
    parameter int                  AW        = 9,
    parameter int                  PKT_WORDS = 32,
    parameter logic [MARKER_W-1:0] MARKER    = MARKER_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              StrobeIn,
    input  logic              endRun,
    output logic [DATA_W-1:0] TxData,
    output logic              TxValid,
    input  logic              TxReady,
    output logic              TxSOP,
    output logic              TxEOP,
    output logic              Overflow,
    output logic [15:0]       DropCount,
    output logic              RunDone
);

    localparam logic [AW:0] PKT_OCC = (AW+1)'(PKT_WORDS);
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic [SEQ_W-1:0]    r_seq;
    logic [AW:0]         r_len;
    logic [AW:0]         r_cnt;
    logic [DATA_W-1:0]   r_xor;
    logic                r_end_d1;
    logic                r_end_d2;
    logic                r_flush;
    logic                r_ovf;
    logic [15:0]         r_drop;

    logic [DATA_W-1:0]   w_head;
    logic                w_full;
    logic                w_empty;
    logic [AW:0]         w_count;
    logic                w_xfer;
    logic                w_pop;
    logic                w_start;
    logic                w_start_full;
    logic                w_done;
    logic [AW:0]         w_len;

    ether_fifo #(
        .AW (AW)
    ) u_fifo (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_wr    (StrobeIn),
        .i_wdata (DataIn),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_xfer       = TxValid && TxReady;
    assign w_pop        = (r_state == S_PAY) && w_xfer;
    assign w_start_full = (w_count >= PKT_OCC);
    assign w_start      = (r_state == S_IDLE) &&
                          (w_start_full || (r_flush && !w_empty));
    assign w_done       = (r_state == S_IDLE) && r_flush && w_empty;
    assign w_len        = w_start_full ? PKT_OCC : w_count;

    assign Overflow  = r_ovf;
    assign DropCount = r_drop;

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and framed output word for the current state.
    always_comb begin
        w_next  = r_state;
        TxData  = '0;
        TxValid = 1'b0;
        TxSOP   = 1'b0;
        TxEOP   = 1'b0;
        RunDone = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_HDR;
                end else if (w_done) begin
                    RunDone = 1'b1;
                end
            end
            S_HDR: begin
                TxValid = 1'b1;
                TxSOP   = 1'b1;
                TxData  = {MARKER, r_seq};
                if (TxReady) begin
                    w_next = S_LEN;
                end
            end
            S_LEN: begin
                TxValid = 1'b1;
                TxData  = DATA_W'(r_len);
                if (TxReady) begin
                    w_next = S_PAY;
                end
            end
            S_PAY: begin
                TxValid = 1'b1;
                TxData  = w_head;
                if (TxReady && ((r_cnt + ONE) == r_len)) begin
                    w_next = S_TRL;
                end
            end
            S_TRL: begin
                TxValid = 1'b1;
                TxEOP   = 1'b1;
                TxData  = r_xor;
                if (TxReady) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Packet bookkeeping, flush tracking and drop statistics.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_seq    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_xor    <= '0;
            r_end_d1 <= 1'b0;
            r_end_d2 <= 1'b0;
            r_flush  <= 1'b0;
            r_ovf    <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_end_d1 <= endRun;
            r_end_d2 <= r_end_d1;
            if (w_done) begin
                r_flush <= 1'b0;
            end else if (r_end_d2) begin
                r_flush <= 1'b1;
            end
            if (w_start) begin
                r_len <= w_len;
                r_cnt <= '0;
                r_xor <= '0;
            end
            if (w_pop) begin
                r_cnt <= r_cnt + ONE;
                r_xor <= r_xor ^ w_head;
            end
            if ((r_state == S_TRL) && w_xfer) begin
                r_seq <= r_seq + 8'd1;
            end
            if (StrobeIn && w_full) begin
                r_ovf <= 1'b1;
                if (r_drop != 16'hFFFF) begin
                    r_drop <= r_drop + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/ether_packetizer.md
Name: ether_packetizer

Overview:
- Sits directly downstream of the 12-to-16-bit repacker in the event-builder output path.
- Buffers its 16-bit word stream in a FIFO.
- Frames the words into packets for the Ethernet output interface: header word, length word, payload, XOR trailer.
- Flushes a final short packet at end of run and signals completion.

Parameters:
- AW, 9, FIFO address width; FIFO depth = 2**AW words.
- PKT_WORDS, 32, nominal payload words per packet (2..2**AW).
- MARKER, 8'hA5, upper byte of the header word.

Ports:
- Clock  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-low; Reset=0 at a rising edge resets the block.
- DataIn  in  16  payload word from the repacker.
- StrobeIn  in  1  DataIn valid this cycle; no backpressure upstream.
- endRun  in  1  one-clock end-of-run pulse, same timing as the one given to the repacker.
- TxData  out  16  framed word to the Ethernet interface.
- TxValid  out  1  TxData valid.
- TxReady  in  1  Ethernet interface accepts TxData when TxValid&&TxReady.
- TxSOP  out  1  marks the header word.
- TxEOP  out  1  marks the trailer word.
- Overflow  out  1  sticky: a word was dropped because the FIFO was full.
- DropCount  out  16  count of dropped words, saturating at 16'hFFFF.
- RunDone  out  1  one-clock pulse after the final packet of a run has been accepted.

Behaviour:
- Reset values: TxValid=0, TxSOP=0, TxEOP=0, TxData=0, Overflow=0, DropCount=0, RunDone=0. FIFO is emptied, Seq=0, FSM goes to IDLE, flush is not pending.
- Reset mid-packet abandons the packet; no EOP is emitted.
- FIFO write: on StrobeIn when not full. When full, the word is discarded, Overflow is set, DropCount increments.
- FIFO read and write in the same cycle are allowed; occupancy is unchanged.
- Flush timing: endRun is delayed 2 clocks internally before setting FlushPend. This lets the repacker's flushed partial word land in the FIFO first.
- Output handshake: a word transfers on TxValid&&TxReady. While TxValid=1 && TxReady=0, TxData, TxSOP and TxEOP hold stable. TxValid never drops without a transfer.
- Packet start condition, evaluated in IDLE:
  - occupancy >= PKT_WORDS, giving Len = PKT_WORDS; or
  - FlushPend && occupancy > 0, giving Len = min(occupancy, PKT_WORDS).
  - Len is latched at packet start.
- FSM states and transitions:
  - IDLE -> HDR when the start condition holds.
  - HDR: TxData = {MARKER, Seq}, TxSOP=1 -> LEN on transfer.
  - LEN: TxData = Len -> PAY on transfer.
  - PAY: TxData = FIFO head; pops on each transfer; running XOR accumulates each word. After Len transfers -> TRL.
  - TRL: TxData = XOR of the Len payload words, TxEOP=1. On transfer: Seq <= Seq+1 (8-bit wrap 255->0), then -> IDLE.
- IDLE with FlushPend && occupancy==0: RunDone pulses 1 cycle and FlushPend clears.
  - Covers an empty FIFO at flush: no packet, RunDone only.
  - Seq is not reset at end of run.
- Latency: the earliest TxValid for HDR is 1 cycle after the start condition is met in IDLE. Consecutive states may transfer on back-to-back cycles. The FIFO read path must sustain 1 word/cycle in PAY with TxReady held high.
- endRun while FlushPend is already set has no further effect.
- Words arriving during a flush are packed normally and extend the flush.

Decomposition:
- Shared package (ether_pkg):
  - FSM state encoding (IDLE, HDR, LEN, PAY, TRL).
  - MARKER default.
  - Header/trailer field widths.
- One sub-module: ether_fifo, a synchronous FIFO (parameter AW, 16-bit data). It provides full, empty, occupancy and first-word-fall-through read data.

Test Plan:
- PKT_WORDS=4, TxReady=1: write 1,2,3,4 -> TxData A500,0004,0001,0002,0003,0004,0004. SOP is on the first word, EOP on the last, and the trailer is 1^2^3^4 = 0004. Next packet header is A501.
- PKT_WORDS=4: write 10,20,30, pulse endRun -> packet A5xx,0003,0010,0020,0030,0000. 10^20^30 = 0000 in hex. RunDone pulses 1 cycle after the trailer transfer.
- TxReady toggled 0/1 every cycle during a 4-word packet -> each word is held while TxReady=0. The sequence is identical to the first test with no duplication or loss.
- AW=2 (depth 4), TxReady=0, 6 strobes -> Overflow=1, DropCount=2. After TxReady=1 the first 4 words emerge in order.
- endRun with an empty FIFO -> RunDone pulses, no TxValid.
- Reset=0 asserted mid-PAY, then released -> all outputs are at reset values, and the next packet header is A500.
- 256 packets -> Seq wraps; the 257th header is A500.
